// File: rtl/axi_lite_slave_if.sv
// AXI-Lite style bus bundle for axi_lite_slave: 4-bit address, 8-bit data,
// 4-bit write response. Clock and reset stay outside the bundle.
//   AR : read_address, AR_VALID -> / <- AR_READY
//   R  : data_read, R_VALID <- / -> R_READY
//   AW : write_address, AW_VALID -> / <- AW_READY
//   W  : data_write, W_VALID -> / <- W_READY
//   B  : BRESPONSE, B_VALID <- / -> B_READY
interface axi_lite_slave_if;
   logic [3:0] read_address;
   logic       AR_VALID;
   logic       AR_READY;
   logic [7:0] data_read;
   logic       R_VALID;
   logic       R_READY;
   logic [3:0] write_address;
   logic       AW_VALID;
   logic       AW_READY;
   logic [7:0] data_write;
   logic       W_VALID;
   logic       W_READY;
   logic [3:0] BRESPONSE;
   logic       B_VALID;
   logic       B_READY;

   modport slave (
      input  read_address, AR_VALID, R_READY,
      input  write_address, AW_VALID, data_write, W_VALID, B_READY,
      output AR_READY, data_read, R_VALID,
      output AW_READY, W_READY, BRESPONSE, B_VALID
   );

   modport master (
      output read_address, AR_VALID, R_READY,
      output write_address, AW_VALID, data_write, W_VALID, B_READY,
      input  AR_READY, data_read, R_VALID,
      input  AW_READY, W_READY, BRESPONSE, B_VALID
   );
endinterface

// File: rtl/axi_lite_slave.sv
// axi_lite_slave: 16 x 8 register file behind an AXI-Lite style slave.
// Ports:
//   clk  - sole clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - axi_lite_slave_if.slave (AR/R/AW/W/B channels)
// Parameters:
//   RESET_DATA - reset value of every register entry
//   ID_VALUE   - constant returned at address 4'hF when protection is built in
// Build option:
//   AXI_SLV_RO_PROTECT_EN - addresses 4'hE/4'hF become read-only: writes are
//   dropped with SLVERR, 4'hF reads ID_VALUE, 4'hE reads RESET_DATA.
module axi_lite_slave #(
   parameter logic [7:0] RESET_DATA = 8'h00,
   parameter logic [7:0] ID_VALUE   = 8'hA5
) (
   input logic             clk,
   input logic             rst,
   axi_lite_slave_if.slave bus
);

   localparam logic [3:0] RESP_OKAY   = 4'h0;
   localparam logic [3:0] RESP_SLVERR = 4'h2;

   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   // register file
   logic [7:0] mem_q [16];
   logic [7:0] mem_d [16];

   // read path
   r_state_t   r_state_q;
   logic       ar_ready_q;
   logic       r_valid_q;
   logic [7:0] data_read_q;
   logic [7:0] rd_val;

   // write path holding registers and response
   logic       aw_full_q, aw_full_d;
   logic [3:0] aw_addr_q, aw_addr_d;
   logic       w_full_q, w_full_d;
   logic [7:0] w_data_q, w_data_d;
   logic       b_valid_q, b_valid_d;
   logic [3:0] bresp_q, bresp_d;

   logic       aw_hs, w_hs, b_hs, commit, wr_ok;
   logic [3:0] commit_addr;
   logic [7:0] commit_data;

   // ---------------- read path ----------------
   // Read value sampled from mem_q before this edge's commit lands, so a
   // same-edge read/write to one address returns the old data.
   always_comb begin
      rd_val = mem_q[bus.read_address];
`ifdef AXI_SLV_RO_PROTECT_EN
      if (bus.read_address == 4'hF)
         rd_val = ID_VALUE;
      else if (bus.read_address == 4'hE)
         rd_val = RESET_DATA;
`endif
   end

`ifndef AXI_SLV_RO_PROTECT_EN
   logic unused_id;
   assign unused_id = ^ID_VALUE;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state_q   <= R_IDLE;
         ar_ready_q  <= 1'b1;
         r_valid_q   <= 1'b0;
         data_read_q <= 8'h00;
      end else begin
         case (r_state_q)
            R_IDLE: if (bus.AR_VALID && ar_ready_q) begin
               r_state_q   <= R_DATA;
               ar_ready_q  <= 1'b0;
               r_valid_q   <= 1'b1;
               data_read_q <= rd_val;
            end
            R_DATA: if (bus.R_READY && r_valid_q) begin
               r_state_q   <= R_IDLE;
               ar_ready_q  <= 1'b1;
               r_valid_q   <= 1'b0;
               data_read_q <= 8'h00;
            end
            default: begin
               r_state_q   <= R_IDLE;
               ar_ready_q  <= 1'b1;
               r_valid_q   <= 1'b0;
               data_read_q <= 8'h00;
            end
         endcase
      end
   end

   assign bus.AR_READY  = ar_ready_q;
   assign bus.R_VALID   = r_valid_q;
   assign bus.data_read = data_read_q;

   // ---------------- write path ----------------
   // Readies drop while a response is pending, so a commit can never
   // overlap an outstanding B.
   assign bus.AW_READY = !aw_full_q && !b_valid_q;
   assign bus.W_READY  = !w_full_q && !b_valid_q;

   assign aw_hs = bus.AW_VALID && bus.AW_READY;
   assign w_hs  = bus.W_VALID && bus.W_READY;
   assign b_hs  = bus.B_VALID && bus.B_READY;

   // Commit as soon as both halves are held or arriving on this edge.
   assign commit      = (aw_full_q || aw_hs) && (w_full_q || w_hs);
   assign commit_addr = aw_full_q ? aw_addr_q : bus.write_address;
   assign commit_data = w_full_q ? w_data_q : bus.data_write;

`ifdef AXI_SLV_RO_PROTECT_EN
   assign wr_ok = (commit_addr < 4'hE);
`else
   assign wr_ok = 1'b1;
`endif

   always_comb begin
      aw_full_d = aw_full_q;
      aw_addr_d = aw_addr_q;
      w_full_d  = w_full_q;
      w_data_d  = w_data_q;
      b_valid_d = b_valid_q;
      bresp_d   = bresp_q;
      mem_d     = mem_q;

      if (aw_hs) begin
         aw_full_d = 1'b1;
         aw_addr_d = bus.write_address;
      end
      if (w_hs) begin
         w_full_d = 1'b1;
         w_data_d = bus.data_write;
      end

      if (b_hs) begin
         b_valid_d = 1'b0;
         bresp_d   = RESP_OKAY;
      end

      if (commit) begin
         aw_full_d = 1'b0;
         w_full_d  = 1'b0;
         b_valid_d = 1'b1;
         bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
         if (wr_ok)
            mem_d[commit_addr] = commit_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         aw_full_q <= 1'b0;
         aw_addr_q <= 4'h0;
         w_full_q  <= 1'b0;
         w_data_q  <= 8'h00;
         b_valid_q <= 1'b0;
         bresp_q   <= RESP_OKAY;
         mem_q     <= '{default: RESET_DATA};
      end else begin
         aw_full_q <= aw_full_d;
         aw_addr_q <= aw_addr_d;
         w_full_q  <= w_full_d;
         w_data_q  <= w_data_d;
         b_valid_q <= b_valid_d;
         bresp_q   <= bresp_d;
         mem_q     <= mem_d;
      end
   end

   assign bus.B_VALID   = b_valid_q;
   assign bus.BRESPONSE = bresp_q;

endmodule

// File: tb/tb_axi_lite_slave.sv
// Directed bench for axi_lite_slave: expected read data and write responses
// are queued when a request is driven and popped when the DUT answers.
module tb_axi_lite_slave;
   localparam logic [7:0] RST_D = 8'h00;
   localparam logic [7:0] ID_V  = 8'hA5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axi_lite_slave_if bus ();

   axi_lite_slave #(.RESET_DATA(RST_D), .ID_VALUE(ID_V)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] exp_mem [16];
   logic [7:0] rq [$];
   logic [3:0] bq [$];

`ifdef AXI_SLV_RO_PROTECT_EN
   localparam bit PROT = 1'b1;
`else
   localparam bit PROT = 1'b0;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic writable(input logic [3:0] a);
      return !(PROT && (a >= 4'hE));
   endfunction

   function automatic logic [7:0] exp_read(input logic [3:0] a);
      if (PROT && a == 4'hF) return ID_V;
      if (PROT && a == 4'hE) return RST_D;
      return exp_mem[a];
   endfunction

   function automatic logic [3:0] exp_resp(input logic [3:0] a);
      return writable(a) ? 4'h0 : 4'h2;
   endfunction

   task automatic chk_idle(input string tag);
      chk({tag, "_ar_ready"}, bus.AR_READY, 1);
      chk({tag, "_r_valid"}, bus.R_VALID, 0);
      chk({tag, "_data_read"}, bus.data_read, 0);
      chk({tag, "_aw_ready"}, bus.AW_READY, 1);
      chk({tag, "_w_ready"}, bus.W_READY, 1);
      chk({tag, "_b_valid"}, bus.B_VALID, 0);
      chk({tag, "_bresp"}, bus.BRESPONSE, 0);
   endtask

   // Inputs change on negedge; DUT samples on posedge; outputs checked on
   // the following negedge.
   task automatic do_read(input logic [3:0] a, input int hold);
      logic [7:0] d;
      bus.AR_VALID = 1'b1;
      bus.read_address = a;
      bus.R_READY = 1'b0;
      rq.push_back(exp_read(a));
      @(negedge clk);
      bus.AR_VALID = 1'b0;
      d = rq.pop_front();
      chk("r_valid", bus.R_VALID, 1);
      chk("rdata", bus.data_read, d);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("r_hold_valid", bus.R_VALID, 1);
         chk("r_hold_data", bus.data_read, d);
         chk("ar_ready_busy", bus.AR_READY, 0);
      end
      bus.R_READY = 1'b1;
      @(negedge clk);
      bus.R_READY = 1'b0;
      chk("r_done_valid", bus.R_VALID, 0);
      chk("r_done_data", bus.data_read, 0);
      chk("r_done_ar_ready", bus.AR_READY, 1);
   endtask

   task automatic do_write(input logic [3:0] a, input logic [7:0] d, input int aw_lead, input int b_hold);
      logic [3:0] r;
      bus.AW_VALID = 1'b1;
      bus.write_address = a;
      for (int i = 0; i < aw_lead; i++) begin
         @(negedge clk);
         bus.AW_VALID = 1'b0;
         chk("aw_ready_held", bus.AW_READY, 0);
         chk("w_ready_open", bus.W_READY, 1);
         chk("b_valid_early", bus.B_VALID, 0);
      end
      bus.W_VALID = 1'b1;
      bus.data_write = d;
      bus.B_READY = (b_hold == 0);
      bq.push_back(exp_resp(a));
      if (writable(a)) exp_mem[a] = d;
      @(negedge clk);
      bus.AW_VALID = 1'b0;
      bus.W_VALID = 1'b0;
      r = bq.pop_front();
      chk("b_valid", bus.B_VALID, 1);
      chk("bresp", bus.BRESPONSE, r);
      for (int i = 0; i < b_hold; i++) begin
         @(negedge clk);
         chk("b_hold_valid", bus.B_VALID, 1);
         chk("b_hold_resp", bus.BRESPONSE, r);
         chk("b_hold_aw_ready", bus.AW_READY, 0);
         chk("b_hold_w_ready", bus.W_READY, 0);
      end
      bus.B_READY = 1'b1;
      @(negedge clk);
      bus.B_READY = 1'b0;
      chk("b_done_valid", bus.B_VALID, 0);
      chk("b_done_resp", bus.BRESPONSE, 0);
      chk("b_done_aw_ready", bus.AW_READY, 1);
      chk("b_done_w_ready", bus.W_READY, 1);
   endtask

   initial begin
      logic [7:0] d;
      logic [3:0] r;
      bus.read_address = 4'h0; bus.AR_VALID = 1'b0; bus.R_READY = 1'b0;
      bus.write_address = 4'h0; bus.AW_VALID = 1'b0;
      bus.data_write = 8'h00; bus.W_VALID = 1'b0; bus.B_READY = 1'b0;
      for (int i = 0; i < 16; i++) exp_mem[i] = RST_D;

      // reset state
      #1 rst = 1'b0;
      #2 chk_idle("reset");
      @(negedge clk);
      rst = 1'b1;

      // same-edge AW/W, then read back
      do_write(4'h3, 8'h5C, 0, 0);
      do_read(4'h3, 0);

      // AW leads W by 3 cycles
      do_write(4'h7, 8'h11, 3, 0);
      do_read(4'h7, 0);

      // B back-pressure for 4 cycles
      do_write(4'h4, 8'hAB, 0, 4);
      do_read(4'h4, 0);

      // R back-pressure for 3 cycles
      do_read(4'h5, 3);

      // same-edge AR(5) and commit(5, FF): old data returned
      bus.AR_VALID = 1'b1; bus.read_address = 4'h5; bus.R_READY = 1'b0;
      bus.AW_VALID = 1'b1; bus.write_address = 4'h5;
      bus.W_VALID = 1'b1; bus.data_write = 8'hFF; bus.B_READY = 1'b1;
      rq.push_back(exp_read(4'h5));
      bq.push_back(exp_resp(4'h5));
      exp_mem[5] = 8'hFF;
      @(negedge clk);
      bus.AR_VALID = 1'b0; bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0;
      d = rq.pop_front();
      r = bq.pop_front();
      chk("coll_rdata", bus.data_read, d);
      chk("coll_r_valid", bus.R_VALID, 1);
      chk("coll_b_valid", bus.B_VALID, 1);
      chk("coll_bresp", bus.BRESPONSE, r);
      bus.R_READY = 1'b1;
      @(negedge clk);
      bus.R_READY = 1'b0; bus.B_READY = 1'b0;
      chk_idle("coll_done");
      do_read(4'h5, 0);

      // top addresses: protected or plain depending on build
      do_write(4'hF, 8'h33, 0, 0);
      do_read(4'hF, 0);
      do_write(4'hE, 8'h66, 0, 0);
      do_read(4'hE, 0);

      // reset during an open read and a held AW
      bus.AR_VALID = 1'b1; bus.read_address = 4'h3; bus.R_READY = 1'b0;
      bus.AW_VALID = 1'b1; bus.write_address = 4'h9;
      @(negedge clk);
      bus.AR_VALID = 1'b0; bus.AW_VALID = 1'b0;
      chk("pre_rst_r_valid", bus.R_VALID, 1);
      chk("pre_rst_aw_ready", bus.AW_READY, 0);
      #2 rst = 1'b0;
      #1 chk_idle("async_rst");
      for (int i = 0; i < 16; i++) exp_mem[i] = RST_D;
      @(negedge clk);
      rst = 1'b1;

      // W alone after reset must not commit against the aborted AW
      bus.W_VALID = 1'b1; bus.data_write = 8'h77;
      @(negedge clk);
      bus.W_VALID = 1'b0;
      chk("w_only_b_valid", bus.B_VALID, 0);
      chk("w_only_w_ready", bus.W_READY, 0);
      chk("w_only_aw_ready", bus.AW_READY, 1);
      bus.AW_VALID = 1'b1; bus.write_address = 4'h2; bus.B_READY = 1'b1;
      bq.push_back(exp_resp(4'h2));
      exp_mem[2] = 8'h77;
      @(negedge clk);
      bus.AW_VALID = 1'b0;
      r = bq.pop_front();
      chk("late_aw_b_valid", bus.B_VALID, 1);
      chk("late_aw_bresp", bus.BRESPONSE, r);
      @(negedge clk);
      bus.B_READY = 1'b0;
      chk_idle("late_aw_done");
      do_read(4'h2, 0);
      do_read(4'h3, 0);
      do_read(4'h9, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
